// File: rtl/softmax_layer.sv
// softmax_layer: iterative float32 softmax over a 10-element class-score vector.
// Free-runs LOAD -> EXP x10 -> DIV x10 -> UPDATE; exp is a degree-6 Taylor series in Horner form.
module softmax_layer #(
    parameter int datawidth = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [datawidth-1:0] inputlayer  [0:9][0:0][0:0],
    output logic [datawidth-1:0] outputlayer [0:9][0:0][0:0]
);

    // state  | meaning
    // IDLE   | post-reset, one cycle
    // LOAD   | snapshot inputs, clear sum, idx = 0
    // EXP    | e[idx] = exp(snap[idx]), sum += e[idx]; 10 cycles
    // DIV    | q[idx] = e[idx] / sum; 10 cycles
    // UPDATE | publish all q to outputlayer at once, back to LOAD

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        EXP    = 3'd2,
        DIV    = 3'd3,
        UPDATE = 3'd4
    } state_t;

    localparam logic [31:0] c_one   = 32'h3f800000;
    localparam logic [31:0] c_half  = 32'h3f000000;
    localparam logic [31:0] c_third = 32'h3eaaaaab;
    localparam logic [31:0] c_qtr   = 32'h3e800000;
    localparam logic [31:0] c_fifth = 32'h3e4ccccd;
    localparam logic [31:0] c_sixth = 32'h3e2aaaab;
    localparam logic [30:0] c_clamp = 31'h40800000;

    // Float32 units flush subnormals to zero, truncate, and saturate overflow to infinity.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic              s;
        logic [47:0]       p;
        logic signed [9:0] ea;
        logic signed [9:0] eb;
        logic signed [9:0] e;
        logic [22:0]       m;
        s  = a[31] ^ b[31];
        p  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        ea = {2'b00, a[30:23]};
        eb = {2'b00, b[30:23]};
        e  = ea + eb - 10'sd127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 10'sd1;
        end else begin
            m = p[45:23];
        end
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e <= 10'sd0)
            fp_mul = {s, 31'd0};
        else if (e >= 10'sd255)
            fp_mul = {s, 8'hff, 23'd0};
        else
            fp_mul = {s, e[7:0], m};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       big;
        logic [31:0]       sml;
        logic [7:0]        d;
        logic [26:0]       mb;
        logic [26:0]       ms;
        logic [26:0]       df;
        logic [27:0]       sm;
        logic [4:0]        lz;
        logic signed [9:0] e;
        if (a[30:0] >= b[30:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        fp_add = 32'd0;
        if (big[30:23] == 8'd0) begin
            fp_add = 32'd0;
        end else if (sml[30:23] == 8'd0) begin
            fp_add = big;
        end else begin
            d  = big[30:23] - sml[30:23];
            mb = {1'b1, big[22:0], 3'b000};
            ms = {1'b1, sml[22:0], 3'b000} >> d;
            e  = {2'b00, big[30:23]};
            if (big[31] == sml[31]) begin
                sm = {1'b0, mb} + {1'b0, ms};
                if (sm[27]) begin
                    e = e + 10'sd1;
                    if (e >= 10'sd255)
                        fp_add = {big[31], 8'hff, 23'd0};
                    else
                        fp_add = {big[31], e[7:0], sm[26:4]};
                end else begin
                    fp_add = {big[31], e[7:0], sm[25:3]};
                end
            end else begin
                df = mb - ms;
                lz = 5'd27;
                for (int i = 26; i >= 0; i--) begin
                    if (df[i] && lz == 5'd27)
                        lz = 5'(26 - i);
                end
                if (df != 27'd0) begin
                    df = df << lz;
                    e  = e - $signed({5'd0, lz});
                    if (e > 10'sd0)
                        fp_add = {big[31], e[7:0], df[25:3]};
                end
            end
        end
    endfunction

    function automatic logic [31:0] fp_div(input logic [31:0] a, input logic [31:0] b);
        logic              s;
        logic [48:0]       q;
        logic signed [9:0] ea;
        logic signed [9:0] eb;
        logic signed [9:0] e;
        logic [22:0]       m;
        s  = a[31] ^ b[31];
        q  = {1'b1, a[22:0], 25'd0} / {25'd0, 1'b1, b[22:0]};
        ea = {2'b00, a[30:23]};
        eb = {2'b00, b[30:23]};
        e  = ea - eb + 10'sd127;
        // mantissa ratio lies in (0.5, 2): bit 25 set means ratio >= 1
        if (q[25]) begin
            m = q[24:2];
        end else begin
            m = q[23:1];
            e = e - 10'sd1;
        end
        if (b[30:23] == 8'd0)
            fp_div = {s, 8'hff, 23'd0};
        else if (a[30:23] == 8'd0 || e <= 10'sd0)
            fp_div = {s, 31'd0};
        else if (e >= 10'sd255)
            fp_div = {s, 8'hff, 23'd0};
        else
            fp_div = {s, e[7:0], m};
    endfunction

    function automatic logic [31:0] fp_exp(input logic [31:0] x_in);
        logic [31:0] x;
        logic [31:0] t;
        x = (x_in[30:0] > c_clamp) ? {x_in[31], c_clamp} : x_in;
        t = fp_add(c_one, fp_mul(x, c_sixth));
        t = fp_add(c_one, fp_mul(fp_mul(x, c_fifth), t));
        t = fp_add(c_one, fp_mul(fp_mul(x, c_qtr), t));
        t = fp_add(c_one, fp_mul(fp_mul(x, c_third), t));
        t = fp_add(c_one, fp_mul(fp_mul(x, c_half), t));
        fp_exp = fp_add(c_one, fp_mul(x, t));
    endfunction

    state_t      state;
    state_t      state_nxt;
    logic [31:0] snap  [0:9];
    logic [31:0] e_reg [0:9];
    logic [31:0] q_reg [0:9];
    logic [31:0] sum;
    logic [3:0]  idx;
    logic        idx_last;
    logic [31:0] exp_val;
    logic [31:0] quo_val;

    assign idx_last = (idx == 4'd9);
    assign exp_val  = fp_exp(snap[idx]);
    assign quo_val  = fp_div(e_reg[idx], sum);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = LOAD;
            LOAD:    state_nxt = EXP;
            EXP:     if (idx_last) state_nxt = DIV;
            DIV:     if (idx_last) state_nxt = UPDATE;
            UPDATE:  state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum <= 32'd0;
            idx <= 4'd0;
            for (int k = 0; k < 10; k++) begin
                snap[k]              <= 32'd0;
                e_reg[k]             <= 32'd0;
                q_reg[k]             <= 32'd0;
                outputlayer[k][0][0] <= '0;
            end
        end else begin
            unique case (state)
                LOAD: begin
                    for (int k = 0; k < 10; k++)
                        snap[k] <= inputlayer[k][0][0];
                    sum <= 32'd0;
                    idx <= 4'd0;
                end
                EXP: begin
                    e_reg[idx] <= exp_val;
                    sum        <= fp_add(sum, exp_val);
                    idx        <= idx_last ? 4'd0 : idx + 4'd1;
                end
                DIV: begin
                    q_reg[idx] <= quo_val;
                    idx        <= idx_last ? 4'd0 : idx + 4'd1;
                end
                UPDATE: begin
                    for (int k = 0; k < 10; k++)
                        outputlayer[k][0][0] <= q_reg[k];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_layer.sv
// Directed bench for softmax_layer: expected probability vectors are queued when a vector
// is presented in LOAD and popped when the corresponding UPDATE is due.
module tb_softmax_layer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] inputlayer  [0:9][0:0][0:0];
    logic [31:0] outputlayer [0:9][0:0][0:0];

    int  checks   = 0;
    int  failures = 0;
    real exp_q[$];
    real cur_exp [10];
    real vin [10];

    softmax_layer #(.datawidth(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .inputlayer  (inputlayer),
        .outputlayer (outputlayer)
    );

    always #5 clock = ~clock;

    function automatic real f2r(input logic [31:0] f);
        real m;
        int  e;
        if (f[30:23] == 8'd0) return 0.0;
        e = int'(f[30:23]) - 127;
        m = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** e);
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real v);
        logic [63:0] b;
        logic [10:0] e;
        if (v == 0.0) return 32'd0;
        b = $realtobits(v);
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    // Reference exp: clamp to +-4 then the degree-6 Horner polynomial in real arithmetic.
    function automatic real taylor(input real x_in);
        real x;
        real t;
        x = (x_in > 4.0) ? 4.0 : ((x_in < -4.0) ? -4.0 : x_in);
        t = 1.0 + x / 6.0;
        t = 1.0 + x / 5.0 * t;
        t = 1.0 + x / 4.0 * t;
        t = 1.0 + x / 3.0 * t;
        t = 1.0 + x / 2.0 * t;
        return 1.0 + x * t;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_real(input string tag, input int k, input real obs, input real ex, input real tol);
        logic ok;
        ok = ((obs - ex) <= tol) && ((ex - obs) <= tol);
        checks++;
        assert (ok === 1'b1) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%g expected=%g", tag, k, obs, ex);
        end
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 10; k++) begin
            checks++;
            assert (outputlayer[k][0][0] === 32'h00000000) else begin
                failures++;
                $error("FAIL %s[%0d] observed=%h expected=00000000", tag, k, outputlayer[k][0][0]);
            end
        end
    endtask

    task automatic load_vec();
        real q [10];
        real s;
        s = 0.0;
        for (int k = 0; k < 10; k++) begin
            inputlayer[k][0][0] = r2f(vin[k]);
            q[k] = taylor(f2r(inputlayer[k][0][0]));
            s += q[k];
        end
        for (int k = 0; k < 10; k++)
            exp_q.push_back(q[k] / s);
    endtask

    task automatic check_result(input string tag);
        real s;
        real obs;
        s = 0.0;
        checks++;
        assert (exp_q.size() >= 10) else begin
            failures++;
            $error("FAIL %s_queue observed=%0d expected=10", tag, exp_q.size());
        end
        if (exp_q.size() < 10) return;
        for (int k = 0; k < 10; k++) begin
            cur_exp[k] = exp_q.pop_front();
            obs = f2r(outputlayer[k][0][0]);
            s += obs;
            check_real(tag, k, obs, cur_exp[k], 2.0e-3 * cur_exp[k]);
        end
        check_real({tag, "_sum"}, 0, s, 1.0, 1.0e-3);
    endtask

    task automatic check_hold(input string tag);
        real obs;
        for (int k = 0; k < 10; k++) begin
            obs = f2r(outputlayer[k][0][0]);
            check_real(tag, k, obs, cur_exp[k], 2.0e-3 * cur_exp[k]);
        end
    endtask

    task automatic check_exact(input string tag, input int k, input real ex);
        check_real(tag, k, f2r(outputlayer[k][0][0]), ex, 0.01 * ex);
    endtask

    task automatic scramble(input int n);
        repeat (n) begin
            for (int k = 0; k < 10; k++)
                inputlayer[k][0][0] = r2f(real'($urandom_range(0, 6000)) / 1000.0 - 3.0);
            tick(1);
        end
    endtask

    initial begin
        for (int k = 0; k < 10; k++)
            inputlayer[k][0][0] = $urandom();
        tick(50);
        check_zero("reset_hold");

        vin = '{0.0, 0.0, 0.0, 0.0, 0.0, 0.0, 0.0, 0.0, 0.0, 0.0};
        load_vec();
        reset = 1'b1;
        tick(22);
        check_zero("before_first_update");
        tick(1);
        check_result("zeros");
        for (int k = 0; k < 10; k++)
            check_exact("zeros_tenth", k, 0.1);

        vin = '{0.0, 1.0, -1.0, 0.5, 1.0, 0.2, -0.5, 0.3, 0.0, 0.7};
        load_vec();
        tick(1);
        scramble(20);
        check_hold("hold_zeros");
        tick(1);
        check_result("vec_a");
        check_exact("vec_a_ref", 0, 0.06828);
        check_exact("vec_a_ref", 1, 0.18562);
        check_exact("vec_a_ref", 2, 0.02512);
        check_exact("vec_a_ref", 3, 0.11258);
        check_exact("vec_a_ref", 9, 0.13751);

        vin = '{-1.0, 0.7, -0.5, 0.5, -0.66, 0.2, 2.0, -1.0, -0.2, 0.5};
        load_vec();
        tick(1);
        scramble(20);
        check_hold("hold_vec_a");
        tick(1);
        check_result("vec_b");
        check_exact("vec_b_ref", 6, 0.44514);
        check_exact("vec_b_ref", 0, 0.02216);
        check_exact("vec_b_ref", 1, 0.12131);

        for (int k = 0; k < 10; k++)
            vin[k] = real'($urandom_range(0, 4000)) / 1000.0 - 2.0;
        load_vec();
        tick(1);
        scramble(20);
        check_hold("hold_vec_b");
        tick(1);
        check_result("vec_rand");

        vin = '{10.0, -10.0, 5.0, 4.0, 1.0, -5.0, 3.9, 0.0, -4.0, -1.0};
        load_vec();
        tick(21);
        check_hold("hold_vec_rand");
        tick(1);
        check_result("vec_clamp");

        for (int k = 0; k < 10; k++)
            vin[k] = real'($urandom_range(0, 2000)) / 1000.0 - 1.0;
        load_vec();
        tick(16);
        reset = 1'b0;
        #1;
        check_zero("reset_mid_div");
        exp_q.delete();
        tick(5);
        check_zero("reset_held");

        vin = '{0.3, -0.3, 1.5, -1.5, 0.9, 0.1, -0.8, 1.2, -2.0, 0.6};
        load_vec();
        reset = 1'b1;
        tick(22);
        check_zero("no_stale_after_reset");
        tick(1);
        check_result("vec_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
